// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg: command and read-path state encodings shared by the SPI RAM burst block
package spi_ram_pkg;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } rd_state_e;

endpackage

// File: rtl/spi_ram_mem_array.sv
// spi_ram_mem_array: word storage with a synchronous write port and a registered read port, no reset
module spi_ram_mem_array #(
    parameter int MEM_WIDTH = 8,
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_SIZE-1:0] waddr,
    input  logic [MEM_WIDTH-1:0] wdata,
    input  logic                 re,
    input  logic [ADDR_SIZE-1:0] raddr,
    output logic [MEM_WIDTH-1:0] rdata
);

    logic [MEM_WIDTH-1:0] mem [MEM_DEPTH];

    // write commits at the edge; read data is captured only when a read is accepted
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/spi_ram_burst.sv
// spi_ram_burst: command-driven RAM with auto-incrementing pointers and a one-deep read output buffer
module spi_ram_burst
    import spi_ram_pkg::*;
#(
    parameter int MEM_WIDTH = 8,
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8,
    parameter int AUTO_INC  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [MEM_WIDTH+1:0] din,
    input  logic                 rx_valid,
    input  logic                 tx_ack,
    input  logic                 clr_flags,
    output logic [MEM_WIDTH-1:0] dout,
    output logic                 tx_valid,
    output logic                 err,
    output logic                 overrun
);

    localparam logic INC = AUTO_INC != 0;

    rd_state_e            state;
    logic [ADDR_SIZE-1:0] addr_wr, addr_rd, pay_addr;
    logic [MEM_WIDTH-1:0] payload, rdata;
    logic [1:0]           cmd;
    logic                 addr_ok, is_wa, is_wd, is_ra, is_rd, rd_ok, drop, bad_addr, data_seen;

    function automatic logic [ADDR_SIZE-1:0] bump(input logic [ADDR_SIZE-1:0] a);
        return (a == ADDR_SIZE'(MEM_DEPTH - 1)) ? '0 : a + 1'b1;
    endfunction

    assign cmd      = din[MEM_WIDTH+1:MEM_WIDTH];
    assign payload  = din[MEM_WIDTH-1:0];
    assign pay_addr = payload[ADDR_SIZE-1:0];
    assign addr_ok  = 32'(pay_addr) < 32'(MEM_DEPTH);
    assign is_wa    = rx_valid && cmd == CMD_WR_ADDR;
    assign is_wd    = rx_valid && cmd == CMD_WR_DATA;
    assign is_ra    = rx_valid && cmd == CMD_RD_ADDR;
    assign is_rd    = rx_valid && cmd == CMD_RD_DATA;
    // a read fits if the buffer is empty or is being drained this same cycle
    assign rd_ok    = is_rd && (state == ST_EMPTY || tx_ack);
    assign drop     = is_rd && state == ST_FULL && !tx_ack;
    assign bad_addr = (is_wa || is_ra) && !addr_ok;
    assign tx_valid = state == ST_FULL;
    // the array has no reset, so dout reads as zero until a read has actually loaded it
    assign dout     = data_seen ? rdata : '0;

    spi_ram_mem_array #(
        .MEM_WIDTH(MEM_WIDTH),
        .MEM_DEPTH(MEM_DEPTH),
        .ADDR_SIZE(ADDR_SIZE)
    ) u_mem (
        .clk  (clk),
        .we   (is_wd),
        .waddr(addr_wr),
        .wdata(payload),
        .re   (rd_ok),
        .raddr(addr_rd),
        .rdata(rdata)
    );

    // read-path FSM, pointers and sticky flags (a set in the same cycle as a clear wins)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_EMPTY;
            data_seen <= 1'b0;
            err       <= 1'b0;
            overrun   <= 1'b0;
            addr_wr   <= '0;
            addr_rd   <= '0;
        end else begin
            state     <= rd_ok ? ST_FULL : (tx_ack ? ST_EMPTY : state);
            data_seen <= data_seen || rd_ok;
            err       <= bad_addr || (err && !clr_flags);
            overrun   <= drop || (overrun && !clr_flags);
            if (is_wa && addr_ok) addr_wr <= pay_addr;
            else if (is_wd && INC) addr_wr <= bump(addr_wr);
            if (is_ra && addr_ok) addr_rd <= pay_addr;
            else if (rd_ok && INC) addr_rd <= bump(addr_rd);
        end
    end

endmodule

// File: tb/tb_spi_ram_burst.sv
// tb_spi_ram_burst: directed vector table plus hand sequences for reset, range errors and wrap
module tb_spi_ram_burst;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] din = '0;
    logic       rx_valid = 1'b0, rx_valid_b = 1'b0, tx_ack = 1'b0, clr_flags = 1'b0;
    logic [7:0] dout_a, dout_b;
    logic       tv_a, tv_b, err_a, err_b, ov_a, ov_b;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    spi_ram_burst u_a (
        .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid), .tx_ack(tx_ack),
        .clr_flags(clr_flags), .dout(dout_a), .tx_valid(tv_a), .err(err_a), .overrun(ov_a)
    );

    spi_ram_burst #(.MEM_DEPTH(200)) u_b (
        .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid_b), .tx_ack(tx_ack),
        .clr_flags(clr_flags), .dout(dout_b), .tx_valid(tv_b), .err(err_b), .overrun(ov_b)
    );

    typedef struct {
        logic       rv;
        logic [1:0] cmd;
        logic [7:0] pay;
        logic       ack;
        logic       clr;
        logic [7:0] dout;
        logic       tv;
        logic       ov;
        logic [7:0] awr;
        logic [7:0] ard;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic rv, input logic [1:0] cmd, input logic [7:0] pay, input logic ack,
                       input logic clr, input logic [7:0] d, input logic tv, input logic ov,
                       input logic [7:0] awr, input logic [7:0] ard);
        vec_t v;
        v = '{rv, cmd, pay, ack, clr, d, tv, ov, awr, ard};
        vq.push_back(v);
    endtask

    // drive at the falling edge, sample 1 time unit after the following rising edge
    task automatic apply(input logic sel_b, input logic rv, input logic [1:0] cmd, input logic [7:0] pay,
                         input logic ack, input logic clr);
        @(negedge clk);
        rx_valid   = sel_b ? 1'b0 : rv;
        rx_valid_b = sel_b ? rv : 1'b0;
        din        = {cmd, pay};
        tx_ack     = ack;
        clr_flags  = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [26:0] got, input logic [26:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got {dout,tv,err,ov,awr,ard}=%h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [26:0] snap_a();
        return {dout_a, tv_a, err_a, ov_a, u_a.addr_wr, u_a.addr_rd};
    endfunction

    function automatic logic [26:0] snap_b();
        return {dout_b, tv_b, err_b, ov_b, u_b.addr_wr, u_b.addr_rd};
    endfunction

    initial begin
        // burst write then burst read with ack
        add(1, 0, 8'h10, 0, 0, 8'h00, 0, 0, 8'h10, 8'h00);
        add(1, 1, 8'hA1, 0, 0, 8'h00, 0, 0, 8'h11, 8'h00);
        add(1, 1, 8'hB2, 0, 0, 8'h00, 0, 0, 8'h12, 8'h00);
        add(1, 1, 8'hC3, 0, 0, 8'h00, 0, 0, 8'h13, 8'h00);
        add(1, 2, 8'h10, 0, 0, 8'h00, 0, 0, 8'h13, 8'h10);
        add(1, 3, 8'h00, 0, 0, 8'hA1, 1, 0, 8'h13, 8'h11);
        add(0, 0, 8'h00, 1, 0, 8'hA1, 0, 0, 8'h13, 8'h11);
        add(1, 3, 8'h00, 0, 0, 8'hB2, 1, 0, 8'h13, 8'h12);
        add(0, 0, 8'h00, 1, 0, 8'hB2, 0, 0, 8'h13, 8'h12);
        add(1, 3, 8'h00, 0, 0, 8'hC3, 1, 0, 8'h13, 8'h13);
        add(0, 0, 8'h00, 1, 0, 8'hC3, 0, 0, 8'h13, 8'h13);
        // write pointer wrap, read back both sides of the wrap, ack+read same cycle
        add(1, 0, 8'hFF, 0, 0, 8'hC3, 0, 0, 8'hFF, 8'h13);
        add(1, 1, 8'h11, 0, 0, 8'hC3, 0, 0, 8'h00, 8'h13);
        add(1, 1, 8'h22, 0, 0, 8'hC3, 0, 0, 8'h01, 8'h13);
        add(1, 2, 8'hFF, 0, 0, 8'hC3, 0, 0, 8'h01, 8'hFF);
        add(1, 3, 8'h00, 0, 0, 8'h11, 1, 0, 8'h01, 8'h00);
        add(1, 3, 8'h00, 1, 0, 8'h22, 1, 0, 8'h01, 8'h01);
        add(0, 0, 8'h00, 1, 0, 8'h22, 0, 0, 8'h01, 8'h01);
        // overrun, clear, stray ack, idle command ignored
        add(1, 2, 8'h10, 0, 0, 8'h22, 0, 0, 8'h01, 8'h10);
        add(1, 3, 8'h00, 0, 0, 8'hA1, 1, 0, 8'h01, 8'h11);
        add(1, 3, 8'h00, 0, 0, 8'hA1, 1, 1, 8'h01, 8'h11);
        add(0, 0, 8'h00, 0, 1, 8'hA1, 1, 0, 8'h01, 8'h11);
        add(0, 0, 8'h00, 1, 0, 8'hA1, 0, 0, 8'h01, 8'h11);
        add(0, 0, 8'h00, 1, 0, 8'hA1, 0, 0, 8'h01, 8'h11);
        add(0, 0, 8'h55, 0, 0, 8'hA1, 0, 0, 8'h01, 8'h11);
        // overrun set and clear in the same cycle: set wins
        add(1, 3, 8'h00, 0, 0, 8'hB2, 1, 0, 8'h01, 8'h12);
        add(1, 3, 8'h00, 0, 1, 8'hB2, 1, 1, 8'h01, 8'h12);
        add(0, 0, 8'h00, 0, 1, 8'hB2, 1, 0, 8'h01, 8'h12);
        add(0, 0, 8'h00, 1, 0, 8'hB2, 0, 0, 8'h01, 8'h12);
        // read-after-write on the next cycle
        add(1, 0, 8'h20, 0, 0, 8'hB2, 0, 0, 8'h20, 8'h12);
        add(1, 2, 8'h20, 0, 0, 8'hB2, 0, 0, 8'h20, 8'h20);
        add(1, 1, 8'h5A, 0, 0, 8'hB2, 0, 0, 8'h21, 8'h20);
        add(1, 3, 8'h00, 0, 0, 8'h5A, 1, 0, 8'h21, 8'h21);
        add(0, 0, 8'h00, 1, 0, 8'h5A, 0, 0, 8'h21, 8'h21);

        repeat (2) @(negedge clk);
        check("reset_a", snap_a(), 27'h0);
        check("reset_b", snap_b(), 27'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            apply(0, vq[i].rv, vq[i].cmd, vq[i].pay, vq[i].ack, vq[i].clr);
            check($sformatf("vec%0d", i), snap_a(),
                  {vq[i].dout, vq[i].tv, 1'b0, vq[i].ov, vq[i].awr, vq[i].ard});
        end

        // asynchronous reset in the middle of a read burst
        apply(0, 1, 2, 8'h10, 0, 0);
        apply(0, 1, 3, 8'h00, 0, 0);
        check("pre_reset", snap_a(), {8'hA1, 1'b1, 1'b0, 1'b0, 8'h21, 8'h11});
        @(negedge clk);
        rx_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check("async_reset", snap_a(), 27'h0);
        @(negedge clk);
        rst_n = 1'b1;
        apply(0, 1, 2, 8'h11, 0, 0);
        apply(0, 1, 3, 8'h00, 0, 0);
        check("retained", snap_a(), {8'hB2, 1'b1, 1'b0, 1'b0, 8'h00, 8'h12});

        // out-of-range addresses on the 200-word instance, and wrap at its top word
        apply(1, 1, 0, 8'h05, 0, 0);
        check("b_wa_05", snap_b(), {8'h00, 1'b0, 1'b0, 1'b0, 8'h05, 8'h00});
        apply(1, 1, 0, 8'hC8, 0, 0);
        check("b_wa_c8", snap_b(), {8'h00, 1'b0, 1'b1, 1'b0, 8'h05, 8'h00});
        apply(1, 1, 0, 8'hC7, 0, 0);
        check("b_wa_c7", snap_b(), {8'h00, 1'b0, 1'b1, 1'b0, 8'hC7, 8'h00});
        apply(1, 1, 1, 8'h77, 0, 0);
        check("b_wrap", snap_b(), {8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00});
        apply(1, 0, 0, 8'h00, 0, 1);
        check("b_clr", snap_b(), {8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00});
        apply(1, 1, 2, 8'hC8, 0, 0);
        check("b_ra_c8", snap_b(), {8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00});
        apply(1, 1, 2, 8'hC7, 0, 0);
        check("b_ra_c7", snap_b(), {8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'hC7});
        apply(1, 1, 3, 8'h00, 0, 0);
        check("b_rd_wrap", snap_b(), {8'h77, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00});
        apply(1, 0, 0, 8'h00, 1, 1);
        check("b_ack_clr", snap_b(), {8'h77, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_ram_burst.md
SPI_RAM_BURST -- requirements
Module: spi_ram_burst

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- MEM_WIDTH, 8, data word width in bits.
- MEM_DEPTH, 256, number of words; legal range 2..2**ADDR_SIZE.
- ADDR_SIZE, 8, address width; ADDR_SIZE <= MEM_WIDTH.
- AUTO_INC, 1, 1 = post-increment the address pointer after each data access; 0 = pointer holds.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- din, in, MEM_WIDTH+2, {cmd[1:0], payload[MEM_WIDTH-1:0]}.
- rx_valid, in, 1, din valid this cycle.
- tx_ack, in, 1, consumer has taken dout.
- clr_flags, in, 1, clears err and overrun.
- dout, out, MEM_WIDTH, read data.
- tx_valid, out, 1, dout holds unconsumed read data.
- err, out, 1, sticky: out-of-range address received.
- overrun, out, 1, sticky: read command dropped.

Function
REQ-003 Commands SHALL be accepted only when rx_valid=1, at most one per cycle, decoded from din[MEM_WIDTH+1:MEM_WIDTH]: 00 WR_ADDR, 01 WR_DATA, 10 RD_ADDR, 11 RD_DATA.
REQ-004 WR_ADDR/RD_ADDR SHALL load addr_wr/addr_rd from payload[ADDR_SIZE-1:0] if the value < MEM_DEPTH; otherwise the pointer is unchanged and err is set.
REQ-005 WR_DATA SHALL write payload to mem[addr_wr] at the clock edge.
REQ-006 RD_DATA SHALL be accepted when tx_valid=0, or when tx_valid=1 and tx_ack=1 in the same cycle.
- On accept: dout <= mem[addr_rd] and tx_valid <= 1 on the next edge (latency 1 cycle).
REQ-007 RD_DATA arriving while tx_valid=1 and tx_ack=0 SHALL be dropped: dout, tx_valid and addr_rd unchanged; overrun set.
REQ-008 Pointer auto-increment (AUTO_INC=1) SHALL apply to addr_wr after WR_DATA and to addr_rd after an accepted RD_DATA.
- Wrap: MEM_DEPTH-1 -> 0.
- A dropped read does not increment addr_rd.
REQ-009 tx_ack=1 while tx_valid=1 with no accepted read SHALL clear tx_valid on the next edge; dout holds its value.
- tx_ack while tx_valid=0 SHALL be ignored.
REQ-010 Read-after-write SHALL return committed data: WR_DATA at cycle N followed by RD_DATA to the same address at cycle N+1 yields the new word.
REQ-011 rx_valid=0 SHALL leave the pointers and memory unchanged; tx_ack and clr_flags still act.
REQ-012 err and overrun SHALL be sticky until clr_flags=1.
- If set and clear occur in the same cycle, set wins.
REQ-013 The read path SHALL be a 2-state FSM:
- EMPTY (tx_valid=0) -> FULL on an accepted read.
- FULL -> EMPTY on tx_ack with no accepted read.
- FULL -> FULL on tx_ack together with an accepted read (new data).

Reset
REQ-014 rst_n=0 SHALL asynchronously force the following; the memory array is not reset and retains its contents:
- dout=0, tx_valid=0, err=0, overrun=0.
- addr_wr=0, addr_rd=0, FSM=EMPTY.
REQ-015 Reset asserted mid-operation SHALL abort the in-flight read; the first command after deassertion is decoded normally.

Structure
REQ-016 Command encodings (CMD_WR_ADDR, CMD_WR_DATA, CMD_RD_ADDR, CMD_RD_DATA) and the FSM state encodings SHALL live in shared package spi_ram_pkg.
REQ-017 The storage array SHALL be a sub-module spi_ram_mem_array (synchronous write port, registered read port, no reset), parametrised by MEM_WIDTH/MEM_DEPTH/ADDR_SIZE.

Verification
REQ-018 Bench (defaults unless noted) SHALL cover:
- Burst write/read: WR_ADDR 0x10, WR_DATA 0xA1,0xB2,0xC3, RD_ADDR 0x10, 3x(RD_DATA then tx_ack) -> dout 0xA1,0xB2,0xC3, each valid 1 cycle after its command; addr_rd=0x13.
- Wrap: WR_ADDR 0xFF, WR_DATA 0x11,0x22 -> mem[0xFF]=0x11, mem[0x00]=0x22.
- Overrun: RD_DATA, no ack, RD_DATA -> dout keeps first word, overrun=1, addr_rd advanced by 1 only; clr_flags -> overrun=0.
- Out of range (MEM_DEPTH=200): WR_ADDR 0xC8 -> err=1, addr_wr unchanged; WR_ADDR 0xC7 -> accepted.
- Ack+read same cycle: tx_valid=1, tx_ack=1 with RD_DATA -> tx_valid stays 1, dout = next word.
- Async reset mid-burst: rst_n low between clock edges -> outputs 0 immediately; after release, reading address 0x11 returns 0xB2 (memory retained).
